regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Multi-ported general-purpose register file for the CPU datapath: 64 x 32-bit registers, two asynchronous read ports, one synchronous write port.
- Sits between decode (supplies read addresses) and writeback (supplies write address, data and enable).
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 6, address width; depth is 2**ADDR_WIDTH (64 entries).
- BYPASS, 0, when 1 a same-cycle write to a read address is forwarded combinationally to that read port.

Ports:
- clk  input  1  system clock; all writes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  ADDR_WIDTH  read address, port 1.
- ra2  input  ADDR_WIDTH  read address, port 2.
- wa  input  ADDR_WIDTH  write address.
- we  input  1  write enable, active high.
- wd  input  DATA_WIDTH  write data.
- rd1  output  DATA_WIDTH  read data, port 1.
- rd2  output  DATA_WIDTH  read data, port 2.

Behaviour:
- Storage is 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Reset:
  - rst_n low clears every register to 0 immediately, independent of clk.
  - rd1 and rd2 therefore read 0 during reset.
  - Writes are ignored while rst_n is low.
  - Reset deassertion has no other side effect.
- Write:
  - On rising clk with rst_n high, we=1 and wa!=0, reg[wa] <= wd.
  - we=0: no register changes.
  - wa=0: the write is silently discarded.
- Read:
  - Purely combinational, zero-cycle latency.
  - rd1 = reg[ra1], rd2 = reg[ra2].
  - Any read of address 0 returns 0.
  - Both ports may read the same address; each returns the same value.
- Read-during-write, same address, BYPASS=0: the read port shows the old contents until the clock edge, then the new value.
- Read-during-write, same address, BYPASS=1:
  - When we=1, wa!=0 and ra==wa, the read port returns wd combinationally.
  - This forwarding applies to each port independently.
  - No forwarding occurs for address 0 or when rst_n is low.
- X-handling: unknown or undriven addresses give undefined read data. No other state may be corrupted, and no latches may be inferred.
- Only one write port exists, so there are no write-write conflicts.
- Registers hold their value indefinitely between writes.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing reg[5]=0xDEADBEEF -> rd1 with ra1=5 is 0 immediately, before any clk edge; remains 0 after rst_n=1.
- Basic write/read: we=1, wa=1, wd=11, clock edge; then ra1=1, ra2=1 -> rd1=rd2=11. Repeat with wa=63, wd=0xFFFFFFFF -> ra2=63 gives 0xFFFFFFFF.
- Register 0: we=1, wa=0, wd=11, clock edge; ra1=0 -> rd1=0. Discarded write leaves reg[1] unchanged.
- Write enable low: we=0, wa=2, wd=25, clock edge -> ra1=2 reads previous value (0 after reset).
- Read-during-write: reg[3]=7. Set we=1, wa=3, wd=50, ra1=3 before the edge:
  - BYPASS=0: rd1=7 before the edge, 50 after it.
  - BYPASS=1: rd1=50 before the edge.
- Dual-port independence: write reg[1]=10 and reg[2]=20. Set ra1=2, ra2=1 -> rd1=20, rd2=10 simultaneously. Swap addresses -> outputs swap in the same cycle.

Source files
------------

// File: rtl/regfile.sv
// regfile: 2**ADDR_WIDTH x DATA_WIDTH register file, entry 0 reads as zero.
// Ports: clk, rst_n (async low), ra1/ra2 -> rd1/rd2 (comb), wa/we/wd (sync write).
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam bit LP_BYP = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_wr;
  logic w_fwd1;
  logic w_fwd2;

  // Entry 0 is never written, so reset alone keeps it at zero.
  assign w_wr = we && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[wa] <= wd;
    end
  end

  // Forwarding is suppressed in reset so reads stay zero.
  assign w_fwd1 = LP_BYP && rst_n && w_wr && (ra1 == wa);
  assign w_fwd2 = LP_BYP && rst_n && w_wr && (ra2 == wa);

  always_comb begin
    rd1 = r_mem[ra1];
    if (ra1 == '0) rd1 = '0;
    if (w_fwd1) rd1 = wd;
  end

  always_comb begin
    rd2 = r_mem[ra2];
    if (ra2 == '0) rd2 = '0;
    if (w_fwd2) rd2 = wd;
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for regfile, one instance per BYPASS value.
// Array reference model; monitor pops expected reads and compares.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  ra1 = '0;
  logic [5:0]  ra2 = '0;
  logic [5:0]  wa = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  always #5 clk = ~clk;

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYPASS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2),
    .wa(wa), .we(we), .wd(wd), .rd1(rd1_a), .rd2(rd2_a)
  );

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYPASS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2),
    .wa(wa), .we(we), .wd(wd), .rd1(rd1_b), .rd2(rd2_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] a1, a2, b1, b2;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[64];
  int          checks = 0;
  int          errors = 0;
  int          n_apply = 0;
  event        ev_smp;

  function automatic logic [31:0] exp_rd(
    input logic [5:0] ra, input bit byp,
    input bit rst, input bit e, input logic [5:0] a,
    input logic [31:0] d);
    if (byp && rst && e && a != 0 && ra == a) return d;
    if (ra == 0) return 32'h0;
    return m[ra];
  endfunction

  task automatic cmp(input string tag, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", tag, act, req);
    end
  endtask

  // Drive one cycle of inputs after a falling edge; the model
  // updates at the following rising edge.
  task automatic apply(input string tag, input logic [5:0] r1,
                       input logic [5:0] r2, input logic [5:0] a,
                       input bit e, input logic [31:0] d,
                       input bit rst);
    exp_t x;
    ra1 = r1; ra2 = r2; wa = a; we = e; wd = d; rst_n = rst;
    if (!rst) foreach (m[i]) m[i] = 32'h0;
    x.tag = tag;
    x.a1 = exp_rd(r1, 0, rst, e, a, d);
    x.a2 = exp_rd(r2, 0, rst, e, a, d);
    x.b1 = exp_rd(r1, 1, rst, e, a, d);
    x.b2 = exp_rd(r2, 1, rst, e, a, d);
    q.push_back(x);
    n_apply++;
    -> ev_smp;
    @(posedge clk);
    if (rst && e && a != 0) m[a] = d;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(ev_smp);
      #1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        x = q.pop_front();
        cmp({x.tag, ".a.rd1"}, rd1_a, x.a1);
        cmp({x.tag, ".a.rd2"}, rd2_a, x.a2);
        cmp({x.tag, ".b.rd1"}, rd1_b, x.b1);
        cmp({x.tag, ".b.rd2"}, rd2_b, x.b2);
      end
    end
  end

  initial begin : driver
    logic [5:0]  r1, r2, a;
    logic [31:0] d;
    bit          e, rst;
    foreach (m[i]) m[i] = 32'h0;
    @(negedge clk);
    apply("reset",    6'd5,  6'd63, 6'd5,  1, 32'h1234, 0);
    apply("wr1",      6'd1,  6'd1,  6'd1,  1, 32'd11, 1);
    apply("rd1",      6'd1,  6'd1,  6'd0,  0, 32'd0, 1);
    apply("wr63",     6'd0,  6'd63, 6'd63, 1, 32'hFFFFFFFF, 1);
    apply("rd63",     6'd1,  6'd63, 6'd0,  0, 32'd0, 1);
    apply("wr0",      6'd0,  6'd1,  6'd0,  1, 32'd11, 1);
    apply("rd0",      6'd0,  6'd1,  6'd0,  0, 32'd0, 1);
    apply("we0",      6'd2,  6'd0,  6'd2,  0, 32'd25, 1);
    apply("rd2",      6'd2,  6'd1,  6'd0,  0, 32'd0, 1);
    apply("wr3",      6'd0,  6'd0,  6'd3,  1, 32'd7, 1);
    apply("rdw3",     6'd3,  6'd3,  6'd3,  1, 32'd50, 1);
    apply("rd3",      6'd3,  6'd0,  6'd0,  0, 32'd0, 1);
    apply("wr1b",     6'd0,  6'd0,  6'd1,  1, 32'd10, 1);
    apply("wr2b",     6'd0,  6'd0,  6'd2,  1, 32'd20, 1);
    apply("dual",     6'd2,  6'd1,  6'd0,  0, 32'd0, 1);
    apply("swap",     6'd1,  6'd2,  6'd0,  0, 32'd0, 1);
    apply("wr5",      6'd0,  6'd0,  6'd5,  1, 32'hDEADBEEF, 1);
    apply("rd5",      6'd5,  6'd5,  6'd0,  0, 32'd0, 1);
    apply("rst5",     6'd5,  6'd1,  6'd5,  1, 32'h55, 0);
    apply("post_rst", 6'd5,  6'd1,  6'd0,  0, 32'd0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r1 = 6'($urandom); r2 = 6'($urandom); a = 6'($urandom);
      end else begin
        r1 = 6'($urandom_range(0, 7));
        r2 = 6'($urandom_range(0, 7));
        a  = 6'($urandom_range(0, 7));
      end
      e   = ($urandom_range(0, 3) != 0);
      d   = $urandom;
      rst = ($urandom_range(0, 59) != 0);
      apply("rand", r1, r2, a, e, d, rst);
    end
    #20;
    checks++;
    if (q.size() != 0 || n_apply == 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
